// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the DAC SB_PLL40_CORE, clocked only by the 12 MHz reference.
// Define PLL_LOSS_COUNT_EN to build the saturating lock-loss event counter (lost_count).
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 12000,
    parameter int STABLE_CYCLES = 1200,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       core_rst_n,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic       lock_lost,
    output logic [1:0] retry_cnt,
    output logic [7:0] lost_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(STABLE_CYCLES - 1);
    // retry_cnt is only 2 bits, so larger retry budgets cap at 3
    localparam logic [1:0]       MAX_R   = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       sync_q, sync_d;
    logic             pll_resetb_q, pll_resetb_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             pll_ready_q, pll_ready_d;
    logic             pll_fail_q, pll_fail_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_s;
    logic             attempt_fail;

    assign lock_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], pll_lock};
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        retry_d      = retry_q;
        lock_lost_d  = 1'b0;
        attempt_fail = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                if (timer_q == RC_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == LT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == SC_LAST) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    retry_d = 2'd0;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (!lock_s) begin
                    lock_lost_d  = 1'b1;
                    attempt_fail = 1'b1;
                end
            end
            ST_FAIL: timer_d = '0;
            default: begin
                state_d = ST_RST_HOLD;
                timer_d = '0;
            end
        endcase

        if (attempt_fail) begin
            timer_d = '0;
            if (retry_q < MAX_R) begin
                retry_d = retry_q + 2'd1;
                state_d = ST_RST_HOLD;
            end else begin
                state_d = ST_FAIL;
            end
        end

        // restart overrides every transition, but a coincident lock loss is still reported
        if (restart) begin
            state_d = ST_RST_HOLD;
            timer_d = '0;
            retry_d = 2'd0;
        end

        pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        core_rst_n_d = (state_d == ST_RUN);
        pll_ready_d  = (state_d == ST_RUN);
        pll_fail_d   = (state_d == ST_FAIL);
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_RST_HOLD;
            timer_q      <= '0;
            retry_q      <= 2'd0;
            sync_q       <= 2'b00;
            pll_resetb_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            pll_ready_q  <= 1'b0;
            pll_fail_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            sync_q       <= sync_d;
            pll_resetb_q <= pll_resetb_d;
            core_rst_n_q <= core_rst_n_d;
            pll_ready_q  <= pll_ready_d;
            pll_fail_q   <= pll_fail_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] lost_q, lost_d;

    always_comb begin
        lost_d = lost_q;
        if (lock_lost_d && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;
    end

    // cleared only by RESET so the count survives restarts
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) lost_q <= 8'd0;
        else        lost_q <= lost_d;
    end

    assign lost_count = lost_q;
`else
    assign lost_count = 8'd0;
`endif

    assign pll_resetb = pll_resetb_q;
    assign core_rst_n = core_rst_n_q;
    assign pll_ready  = pll_ready_q;
    assign pll_fail   = pll_fail_q;
    assign lock_lost  = lock_lost_q;
    assign retry_cnt  = retry_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed + randomized bench for pll_lock_sequencer against a phase/dwell reference model.
// Honours PLL_LOSS_COUNT_EN the same way the design does.
module tb_pll_lock_sequencer;

    localparam int RC = 4, LT = 20, SC = 8, MR = 2;
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
`ifdef PLL_LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb, core_rst_n, pll_ready, pll_fail, lock_lost;
    logic [1:0] retry_cnt;
    logic [7:0] lost_count;
    logic [2:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    // reference model: current phase, edges spent in it, retries, loss events
    int m_ph, m_dwell, m_retry, m_lost;
    bit m_pulse;
    bit lock_hist[$];

    pll_lock_sequencer #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(16)
    ) dut (
        .REFERENCECLK(clk), .RESET(rst_n), .pll_lock(pll_lock), .restart(restart),
        .pll_resetb(pll_resetb), .core_rst_n(core_rst_n), .pll_ready(pll_ready),
        .pll_fail(pll_fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt),
        .lost_count(lost_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ph = P_RST; m_dwell = 0; m_retry = 0; m_lost = 0; m_pulse = 1'b0;
        lock_hist.delete();
    endfunction

    function automatic void enter(int p);
        m_ph = p; m_dwell = 0;
    endfunction

    // lock is seen by the sequencer two edges after it is sampled
    function automatic void model_edge(bit lock_in, bit rs);
        bit ls, failed;
        lock_hist.push_back(lock_in);
        ls = (lock_hist.size() >= 3) ? lock_hist[lock_hist.size()-3] : 1'b0;
        if (lock_hist.size() > 3) void'(lock_hist.pop_front());
        m_pulse = 1'b0;
        failed  = 1'b0;
        case (m_ph)
            P_RST:  begin m_dwell++; if (m_dwell == RC) enter(P_WAIT); end
            P_WAIT: if (ls) enter(P_STAB);
                    else begin m_dwell++; if (m_dwell == LT) failed = 1'b1; end
            P_STAB: if (!ls) enter(P_WAIT);
                    else begin m_dwell++; if (m_dwell == SC) begin enter(P_RUN); m_retry = 0; end end
            P_RUN:  if (!ls) begin
                        m_pulse = 1'b1;
                        failed  = 1'b1;
                        if (LOSS_EN == 1 && m_lost < 255) m_lost++;
                    end
            default: ;
        endcase
        if (failed) begin
            if (m_retry < MR) begin m_retry++; enter(P_RST); end
            else enter(P_FAIL);
        end
        if (rs) begin enter(P_RST); m_retry = 0; end
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [2:0] ph;
        ph = 3'(m_ph);
        return {14'd0, ph, (m_ph >= P_WAIT && m_ph <= P_RUN), (m_ph == P_RUN), (m_ph == P_RUN),
                (m_ph == P_FAIL), m_pulse, 2'(m_retry), 8'(m_lost)};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {14'd0, state_dbg, pll_resetb, core_rst_n, pll_ready, pll_fail, lock_lost,
                retry_cnt, lost_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(pll_lock, restart);
        #1;
        check(tag, obs_vec(), exp_vec());
    endtask

    task automatic pulse_restart(input string tag);
        restart = 1'b1;
        tick(tag);
        restart = 1'b0;
    endtask

    task automatic run_until(input int target, input int maxc, input string tag);
        int n = 0;
        while (m_ph != target && n < maxc) begin
            tick(tag);
            n++;
        end
        check({tag, "_reach"}, 32'(state_dbg), 32'(target));
    endtask

    initial begin
        int n;
        // reset values
        #1 rst_n = 1'b0;
        #2 model_reset();
        check("reset_vals", obs_vec(), 32'd0);
        repeat (3) tick("rst_held");
        @(negedge clk) rst_n = 1'b1;

        // 1: lock from cycle 6, resetb at cycle 4, RUN after sync + 8 stable edges
        for (int c = 1; c <= 20; c++) begin
            if (c == 6) pll_lock = 1'b1;
            tick("s1");
            if (c == 3)  check("s1_resetb_low", 32'(pll_resetb), 32'd0);
            if (c == 4)  check("s1_resetb_rise", 32'(pll_resetb), 32'd1);
            if (c == 15) check("s1_still_stable", 32'(core_rst_n), 32'd0);
            if (c == 16) check("s1_run", {30'd0, core_rst_n, pll_ready}, 32'd3);
        end
        check("s1_retry", 32'(retry_cnt), 32'd0);

        // 4: lock loss in RUN
        pll_lock = 1'b0;
        tick("s4"); tick("s4");
        tick("s4");
        check("s4_loss", {26'd0, state_dbg, core_rst_n, lock_lost, pll_ready}, 32'h2);
        check("s4_retry", 32'(retry_cnt), 32'd1);
        check("s4_lost", 32'(lost_count), 32'(LOSS_EN));
        tick("s4");
        check("s4_pulse_one", 32'(lock_lost), 32'd0);

        // 2: lock stuck low from a fresh sequence -> FAIL, then restart
        pulse_restart("s2_restart");
        run_until(P_FAIL, 3 * (RC + LT) + 10, "s2");
        check("s2_fail", {29'd0, pll_fail, pll_resetb, core_rst_n}, 32'h4);
        check("s2_retry", 32'(retry_cnt), 32'd2);
        repeat (5) tick("s2_hold");
        pulse_restart("s2_restart2");
        check("s2_after", {27'd0, state_dbg, retry_cnt}, 32'd0);
        check("s2_nofail", 32'(pll_fail), 32'd0);

        // 3: one-cycle drop in STABLE at timer=5
        pll_lock = 1'b1;
        run_until(P_STAB, 30, "s3");
        n = 0;
        while (m_dwell != 5 && n < 20) begin tick("s3"); n++; end
        pll_lock = 1'b0;
        tick("s3_drop");
        pll_lock = 1'b1;
        run_until(P_WAIT, 5, "s3_back");
        check("s3_retry", 32'(retry_cnt), 32'd0);
        run_until(P_STAB, 10, "s3_re");
        n = 0;
        while (state_dbg != 3'd3 && n < 40) begin tick("s3_count"); n++; end
        check("s3_full_stable", 32'(n), 32'(SC));

        // 5: restart on the same edge that sees lock loss in RUN
        pll_lock = 1'b0;
        tick("s5"); tick("s5");
        restart = 1'b1;
        tick("s5_same");
        restart = 1'b0;
        check("s5_state", {27'd0, state_dbg, retry_cnt}, 32'd0);
        check("s5_pulse", 32'(lock_lost), 32'd1);
        check("s5_lost", 32'(lost_count), 32'(2 * LOSS_EN));
        pll_lock = 1'b1;

        // 6: async RESET during STABLE
        run_until(P_STAB, 30, "s6");
        tick("s6"); tick("s6");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("s6_async", obs_vec(), 32'd0);
        tick("s6_held"); tick("s6_held");
        #2 rst_n = 1'b1;
        run_until(P_RUN, 40, "s6_recover");

        // randomized lock jitter with rare restarts
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) pll_lock = ~pll_lock;
            restart = ($urandom_range(0, 99) == 0);
            tick("rand");
        end
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the SB_PLL40_CORE clock generator for the DAC (12 MHz in, 102 MHz out).
- Drives the PLL RESETB pin and watches the PLL LOCK output.
- Releases the downstream core reset only after lock has been continuously stable.
- Handles lock loss with bounded retries and a terminal FAIL state; runs entirely on the 12 MHz reference clock.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low per reset attempt (min 2)
LOCK_TIMEOUT, 12000, cycles allowed in WAIT_LOCK before the attempt is declared failed (1 ms at 12 MHz)
STABLE_CYCLES, 1200, consecutive synced-lock cycles required before core reset release (100 us)
MAX_RETRIES, 3, failed attempts tolerated before FAIL
CNT_W, 16, width of the shared phase timer; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
REFERENCECLK  in   1  12 MHz reference clock; sole clock of the block
RESET         in   1  asynchronous, active-low reset
pll_lock      in   1  PLL LOCK output, asynchronous to REFERENCECLK
restart       in   1  synchronous pulse; forces a fresh sequence from any state
pll_resetb    out  1  to PLL RESETB (active low)
core_rst_n    out  1  active-low reset for PLL-domain logic; consumers re-synchronise into the PLLOUTGLOBAL domain
pll_ready     out  1  high only in RUN
pll_fail      out  1  high only in FAIL
lock_lost     out  1  one-cycle pulse on loss of lock while in RUN
retry_cnt     out  2  failed attempts since last RUN or restart, saturating
lost_count    out  8  lock-loss event counter (see Optional Feature)
state_dbg     out  3  current state encoding

Behaviour:
- Reset (RESET=0, async): state RST_HOLD; timer=0; retry_cnt=0; pll_resetb=0; core_rst_n=0; pll_ready=0; pll_fail=0; lock_lost=0; lost_count=0. All outputs are registered.
- Lock synchroniser: pll_lock passes through 2 flops to give lock_s. Synchroniser flops reset to 0. Response latency to a pll_lock change is 2 cycles plus 1 cycle of state decision.
- RST_HOLD: pll_resetb=0, core_rst_n=0. Timer counts up to RESET_CYCLES-1, then the block goes to WAIT_LOCK, clears the timer and registers pll_resetb=1 on the same edge.
- WAIT_LOCK:
  - lock_s=1: go to STABLE, timer cleared.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s=0: attempt failed (see retry rule).
- STABLE:
  - lock_s=0 in any cycle: return to WAIT_LOCK, timer cleared. Does not consume a retry.
  - Timer reaches STABLE_CYCLES-1 with lock_s=1 throughout: go to RUN. core_rst_n=1 and pll_ready=1 on that edge; retry_cnt cleared.
- RUN:
  - lock_s=0: on the next edge core_rst_n=0, pll_ready=0, lock_lost=1 for one cycle, and lost_count increments.
  - The event counts as a failed attempt.
- Retry rule on a failed attempt:
  - retry_cnt < MAX_RETRIES: retry_cnt+1, go to RST_HOLD, timer cleared.
  - retry_cnt == MAX_RETRIES: go to FAIL.
- FAIL: pll_resetb=0, core_rst_n=0, pll_fail=1. Leaves only on restart or RESET.
- restart=1 in any state: go to RST_HOLD, timer=0, retry_cnt=0, core_rst_n=0, pll_fail=0.
  - restart has priority over every other transition in the same cycle, including lock loss. In that case lock_lost still pulses and lost_count still increments.
- State encoding for state_dbg: RST_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- Counters:
  - Timer wraps never: every path clears it on state change.
  - retry_cnt saturates at 3.
  - lost_count saturates at 255.
- Mid-operation RESET assertion: all outputs return to reset values immediately (asynchronous).

Optional Feature:
Macro PLL_LOSS_COUNT_EN.
- Defined: lost_count is an 8-bit saturating counter as described. It clears only on RESET; restart does not clear it.
- Undefined: counter logic is omitted and lost_count is tied to 8'd0. All other behaviour is identical.

Test Plan:
Params for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release RESET, pll_lock=1 from cycle 6 -> pll_resetb rises at cycle 4; core_rst_n and pll_ready rise 2+1+8 cycles after lock reaches the synchroniser; retry_cnt=0.
2. pll_lock stuck 0 -> two RST_HOLD/WAIT_LOCK cycles (retry_cnt 1, then 2), then FAIL with pll_fail=1, pll_resetb=0; restart pulse -> RST_HOLD, pll_fail=0, retry_cnt=0.
3. In STABLE, drop pll_lock for 1 cycle at timer=5 -> return to WAIT_LOCK; retry_cnt unchanged; full 8 stable cycles required afterwards.
4. In RUN, drop pll_lock -> core_rst_n=0, lock_lost pulses exactly 1 cycle, lost_count=1 (with macro) or 0 (without), retry_cnt=1, state RST_HOLD.
5. restart and lock loss in the same RUN cycle -> RST_HOLD, retry_cnt=0, lock_lost pulses, lost_count increments.
6. Assert RESET during STABLE -> all outputs at reset values with no clock edge required; sequence restarts cleanly on release.
